// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the stopwatch_v2 block.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   typedef logic [3:0] bcd_t;

   localparam int unsigned NUM_DIGITS    = 6;
   localparam bcd_t        MAX_DEC       = 4'd9;
   localparam bcd_t        MAX_SEX       = 4'd5;
   localparam bcd_t        MAX_HR_HI     = 4'd2;
   localparam bcd_t        MAX_HR_LO_TOP = 4'd3;

   // Digit index 0 is cs_lo; the tens of seconds (3) and of minutes (5) roll at 5.
   function automatic bcd_t digit_max(input int unsigned idx);
      return (idx == 3 || idx == 5) ? MAX_SEX : MAX_DEC;
   endfunction

endpackage

// File: rtl/stopwatch_v2_key_debounce.sv
// Key synchroniser + debouncer; emits a one-cycle pulse on an accepted press (1->0).
module key_debounce #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEB_CYC     = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic level,
   output logic press
);

   localparam int unsigned CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

   logic [SYNC_STAGES-1:0] sync;
   logic [CW-1:0]          cnt;
   logic                   synced;
   logic                   accept_c;

   assign synced   = sync[SYNC_STAGES-1];
   assign accept_c = (synced != level) && (cnt == CW'(DEB_CYC - 1));

   // Counter only advances while the synced level disagrees with the accepted one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= '1;
         level <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], key_n};
         press <= accept_c & ~synced;
         if (synced == level) begin
            cnt <= '0;
         end else if (accept_c) begin
            level <= synced;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/stopwatch_v2.sv
// mm:ss.cc stopwatch with debounced toggle keys and lap freeze.
// Optional hour digits (00-23) when STOPWATCH_HOUR_EN is defined.
module stopwatch_v2
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 50_000_000,
   parameter int unsigned TICK_HZ     = 100,
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_clear,
   input  logic        key_start_pause,
   input  logic        key_lap,
   output logic [23:0] disp_bcd,
   output logic        running,
   output logic        paused,
   output logic        frozen,
   output logic        wrap
`ifdef STOPWATCH_HOUR_EN
   ,
   output logic [7:0]  hour_bcd
`endif
);

   localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
   localparam int unsigned DEB_CYC = CLK_HZ / 1000 * DEBOUNCE_MS;
   localparam int unsigned PW      = (DIV > 1) ? $clog2(DIV) : 1;

   logic clear_ev, start_ev, lap_ev;
   logic clear_lvl, start_lvl, lap_lvl;
   logic unused_levels;

   assign unused_levels = &{1'b0, clear_lvl, start_lvl, lap_lvl};

   key_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYC(DEB_CYC)) u_deb_clear (
      .clk(clk), .rst_n(rst_n), .key_n(key_clear), .level(clear_lvl), .press(clear_ev)
   );
   key_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYC(DEB_CYC)) u_deb_start (
      .clk(clk), .rst_n(rst_n), .key_n(key_start_pause), .level(start_lvl), .press(start_ev)
   );
   key_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYC(DEB_CYC)) u_deb_lap (
      .clk(clk), .rst_n(rst_n), .key_n(key_lap), .level(lap_lvl), .press(lap_ev)
   );

   state_t state, state_nxt;
   logic   running_d, paused_d;

   // State register; status flags are registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         running <= 1'b0;
         paused  <= 1'b0;
      end else begin
         state   <= state_nxt;
         running <= running_d;
         paused  <= paused_d;
      end
   end

   // Clear wins over start in the same cycle.
   always_comb begin
      state_nxt = state;
      if (clear_ev) begin
         state_nxt = IDLE;
      end else if (start_ev) begin
         case (state)
            IDLE:    state_nxt = RUN;
            RUN:     state_nxt = PAUSE;
            PAUSE:   state_nxt = RUN;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      running_d = 1'b0;
      paused_d  = 1'b0;
      case (state_nxt)
         RUN:     running_d = 1'b1;
         PAUSE:   paused_d  = 1'b1;
         default: ;
      endcase
   end

   logic [PW-1:0] presc;
   logic          tick_c;

   assign tick_c = (state == RUN) && (presc == PW'(DIV - 1));

   // Prescaler holds through PAUSE so a resume keeps the partial tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
      end else if (clear_ev) begin
         presc <= '0;
      end else if (state == RUN) begin
         presc <= tick_c ? '0 : presc + PW'(1);
      end
   end

   bcd_t [NUM_DIGITS-1:0] dig, dig_nxt;
   logic                  carry_c;
   logic                  wrap_c;

   always_comb begin
      dig_nxt = dig;
      carry_c = tick_c;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (carry_c) begin
            if (dig[i] == digit_max(i)) begin
               dig_nxt[i] = '0;
            end else begin
               dig_nxt[i] = dig[i] + 4'd1;
               carry_c    = 1'b0;
            end
         end
      end
   end

`ifdef STOPWATCH_HOUR_EN
   bcd_t hr_hi, hr_lo, hr_hi_nxt, hr_lo_nxt;

   // Hours roll 23 -> 00, which is the overall wrap point.
   always_comb begin
      hr_hi_nxt = hr_hi;
      hr_lo_nxt = hr_lo;
      wrap_c    = 1'b0;
      if (carry_c) begin
         if (hr_hi == MAX_HR_HI && hr_lo == MAX_HR_LO_TOP) begin
            hr_hi_nxt = '0;
            hr_lo_nxt = '0;
            wrap_c    = 1'b1;
         end else if (hr_lo == MAX_DEC) begin
            hr_lo_nxt = '0;
            hr_hi_nxt = hr_hi + 4'd1;
         end else begin
            hr_lo_nxt = hr_lo + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hr_hi    <= '0;
         hr_lo    <= '0;
         hour_bcd <= '0;
      end else begin
         if (clear_ev) begin
            hr_hi <= '0;
            hr_lo <= '0;
         end else begin
            hr_hi <= hr_hi_nxt;
            hr_lo <= hr_lo_nxt;
         end
         if (!frozen) hour_bcd <= {hr_hi, hr_lo};
      end
   end
`else
   assign wrap_c = carry_c;
`endif

   // Display copies the live count one cycle late unless a lap freeze is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dig      <= '0;
         disp_bcd <= '0;
         frozen   <= 1'b0;
         wrap     <= 1'b0;
      end else begin
         wrap <= wrap_c & ~clear_ev;
         if (clear_ev) begin
            dig    <= '0;
            frozen <= 1'b0;
         end else begin
            dig <= dig_nxt;
            if (lap_ev) frozen <= ~frozen;
         end
         if (!frozen) disp_bcd <= dig;
      end
   end

endmodule
